dvg_frame_sequencer: RTL and testbench

//  Frame-level controller for the vector generator. Issues one dmago pulse per display frame and

---
 rtl/dvg_frame_sequencer_pkg.sv | 20 ++
 rtl/dvg_frame_sequencer_if.sv | 34 +++
 rtl/dvg_frame_sequencer_frame_divider.sv | 34 +++
 rtl/dvg_frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_dvg_frame_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dvg_frame_sequencer_pkg.sv
// Shared definitions for the DVG frame sequencer: FSM state encoding and
// the default frame / watchdog timing used by the top level and sub-modules.
package dvg_frame_sequencer_pkg;

  // 1.5 MHz state clock divided down to a 60 Hz frame rate
  localparam int FRAME_DIV_DEFAULT   = 25000;
  // Longest time a vector program may run before it is forcibly aborted
  localparam int WDOG_CYCLES_DEFAULT = 20000;
  // Counter width; must hold FRAME_DIV-1 and WDOG_CYCLES-1
  localparam int CTR_W_DEFAULT       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DRAW  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

endpackage

// File: rtl/dvg_frame_sequencer_if.sv
// Control/status bundle between the host/power-on logic and the frame
// sequencer. The master side drives the requests, the slave side is the
// sequencer itself.
interface dvg_frame_sequencer_if;
  import dvg_frame_sequencer_pkg::*;

  logic enable;
  logic halt_in;
  logic host_swap_req;
  logic clear_status;

  logic dmago;
  logic dvg_abort;
  logic draw_bank;
  logic host_bank;
  logic host_swap_ack;
  logic busy;
  logic frame_tick;
  logic overrun;
  logic timeout;

  modport master (
    output enable, halt_in, host_swap_req, clear_status,
    input  dmago, dvg_abort, draw_bank, host_bank, host_swap_ack,
           busy, frame_tick, overrun, timeout
  );

  modport slave (
    input  enable, halt_in, host_swap_req, clear_status,
    output dmago, dvg_abort, draw_bank, host_bank, host_swap_ack,
           busy, frame_tick, overrun, timeout
  );

endinterface

// File: rtl/dvg_frame_sequencer_frame_divider.sv
// Free-running modulo-FRAME_DIV counter. frame_tick is a registered
// one-cycle pulse in the cycle after the counter holds FRAME_DIV-1, so the
// first tick arrives FRAME_DIV cycles after reset is released.
module dvg_frame_sequencer_frame_divider
  import dvg_frame_sequencer_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_DEFAULT,
  parameter int CTR_W     = CTR_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(FRAME_DIV - 1);

  logic [CTR_W-1:0] count;

  // Count 0..FRAME_DIV-1 and flag the wrap one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (count == LAST);
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/dvg_frame_sequencer.sv
// Frame-level controller for the vector generator. Starts the vector program
// once per frame, waits for HALT or a watchdog expiry, and owns the
// double-buffered vector RAM bank select, swapping banks only between frames.
module dvg_frame_sequencer
  import dvg_frame_sequencer_pkg::*;
#(
  parameter int FRAME_DIV   = FRAME_DIV_DEFAULT,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT,
  parameter int CTR_W       = CTR_W_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  dvg_frame_sequencer_if.slave bus
);

  localparam logic [CTR_W-1:0] WDOG_LAST = CTR_W'(WDOG_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CTR_W-1:0] wdog;
  logic             frame_tick;
  logic             draw_bank;
  logic             swap_pending;
  logic             swap_ack;
  logic             overrun;
  logic             timeout;
  logic             dmago;
  logic             dvg_abort;
  logic             busy;
  logic             swap_now;

  dvg_frame_sequencer_frame_divider #(
    .FRAME_DIV (FRAME_DIV),
    .CTR_W     (CTR_W)
  ) u_frame_divider (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick)
  );

  // State register; reset abandons any frame in progress without an abort pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore outputs decoded from the current state
  always_comb begin
    next_state = state;
    dmago      = 1'b0;
    dvg_abort  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_tick && bus.enable) begin
          next_state = ST_START;
        end
      end
      ST_START: begin
        dmago      = 1'b1;
        busy       = 1'b1;
        next_state = ST_DRAW;
      end
      ST_DRAW: begin
        busy = 1'b1;
        if (bus.halt_in) begin
          next_state = ST_DONE;
        end else if (wdog == WDOG_LAST) begin
          next_state = ST_ABORT;
        end
      end
      ST_ABORT: begin
        dvg_abort  = 1'b1;
        next_state = ST_IDLE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Watchdog counts DRAW cycles; START rearms it for the new frame
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
    end else if (state == ST_START) begin
      wdog <= '0;
    end else if (state == ST_DRAW) begin
      wdog <= wdog + CTR_W'(1);
    end
  end

  // A swap is taken only at a clean frame end, never after an abort
  assign swap_now = (state == ST_DONE) && (swap_pending || bus.host_swap_req);

  // Bank select and swap bookkeeping; repeated requests collapse into one swap
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_bank    <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack     <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (swap_now) begin
        draw_bank    <= ~draw_bank;
        swap_pending <= 1'b0;
        swap_ack     <= 1'b1;
      end else if (bus.host_swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as clear_status wins
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (frame_tick && busy) begin
        overrun <= 1'b1;
      end else if (bus.clear_status) begin
        overrun <= 1'b0;
      end
      if (state == ST_ABORT) begin
        timeout <= 1'b1;
      end else if (bus.clear_status) begin
        timeout <= 1'b0;
      end
    end
  end

  assign bus.dmago         = dmago;
  assign bus.dvg_abort     = dvg_abort;
  assign bus.busy          = busy;
  assign bus.frame_tick    = frame_tick;
  assign bus.draw_bank     = draw_bank;
  assign bus.host_bank     = ~draw_bank;
  assign bus.host_swap_ack = swap_ack;
  assign bus.overrun       = overrun;
  assign bus.timeout       = timeout;

endmodule

// File: tb/tb_dvg_frame_sequencer.sv
// Bench for dvg_frame_sequencer. Two instances share one clock: one with a
// watchdog shorter than the frame, one with a watchdog longer than the frame
// so that overruns can occur. Both are compared every cycle against a
// frame-level reference model kept in the bench.
module tb_dvg_frame_sequencer;

  localparam int FD = 100;
  localparam int WA = 50;
  localparam int WB = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  dvg_frame_sequencer_if bus_a ();
  dvg_frame_sequencer_if bus_b ();

  dvg_frame_sequencer #(.FRAME_DIV(FD), .WDOG_CYCLES(WA), .CTR_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  dvg_frame_sequencer #(.FRAME_DIV(FD), .WDOG_CYCLES(WB), .CTR_W(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  logic [1:0] en_v   = '0;
  logic [1:0] halt_v = '0;
  logic [1:0] swap_v = '0;
  logic [1:0] clr_v  = '0;

  assign bus_a.enable        = en_v[0];
  assign bus_a.halt_in       = halt_v[0];
  assign bus_a.host_swap_req = swap_v[0];
  assign bus_a.clear_status  = clr_v[0];
  assign bus_b.enable        = en_v[1];
  assign bus_b.halt_in       = halt_v[1];
  assign bus_b.host_swap_req = swap_v[1];
  assign bus_b.clear_status  = clr_v[1];

  logic [8:0] obs_a;
  logic [8:0] obs_b;

  assign obs_a = {bus_a.dmago, bus_a.dvg_abort, bus_a.busy, bus_a.frame_tick, bus_a.draw_bank,
                  bus_a.host_bank, bus_a.host_swap_ack, bus_a.overrun, bus_a.timeout};
  assign obs_b = {bus_b.dmago, bus_b.dvg_abort, bus_b.busy, bus_b.frame_tick, bus_b.draw_bank,
                  bus_b.host_bank, bus_b.host_swap_ack, bus_b.overrun, bus_b.timeout};

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  // Reference model: a frame is described by its dmago cycle and its end cycle
  int cyc;
  int dm[2];
  int fin[2];
  int ack_at[2];
  int halt_at[2];
  int wlen[2];
  bit [1:0] fin_abort;
  bit [1:0] bank;
  bit [1:0] pending;
  bit [1:0] over;
  bit [1:0] tmo;

  // Stimulus controls
  int  halt_delay[2];
  int  swap_mode   = 0;
  bit  random_mode = 1'b0;
  bit  en_level    = 1'b0;
  bit  clr_pulse   = 1'b0;
  bit  force_reset = 1'b0;
  int  delay_tab[10] = '{1, 2, 5, 10, 30, 49, 50, 51, 120, 250};

  task automatic model_clear(input int i);
    dm[i]        = -1;
    fin[i]       = -1;
    ack_at[i]    = -1;
    halt_at[i]   = -1;
    fin_abort[i] = 1'b0;
    bank[i]      = 1'b0;
    pending[i]   = 1'b0;
    over[i]      = 1'b0;
    tmo[i]       = 1'b0;
  endtask

  function automatic logic [8:0] exp_outputs(input int i);
    logic tick_now;
    logic busy_now;
    tick_now = (cyc > 0) && (cyc % FD == 0);
    busy_now = (dm[i] >= 0) && (cyc >= dm[i]) && ((fin[i] < 0) || (cyc < fin[i]));
    return {(dm[i] == cyc), ((fin[i] == cyc) && fin_abort[i]), busy_now, tick_now,
            bank[i], ~bank[i], (ack_at[i] == cyc), over[i], tmo[i]};
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected_v);
    check_count++;
    assert (observed === expected_v) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected_v);
    end
  endtask

  // Advance the model by one cycle using the inputs that were applied in it
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit tick_now;
      bit busy_now;
      bit idle_now;
      bit end_now;
      bit swapped;
      if (reset) begin
        model_clear(i);
      end else begin
        tick_now = (cyc > 0) && (cyc % FD == 0);
        busy_now = (dm[i] >= 0) && (cyc >= dm[i]) && ((fin[i] < 0) || (cyc < fin[i]));
        idle_now = (dm[i] < 0);
        end_now  = (fin[i] == cyc);
        swapped  = 1'b0;
        if (busy_now && (cyc > dm[i]) && (fin[i] < 0)) begin
          if (halt_v[i]) begin
            fin[i]       = cyc + 1;
            fin_abort[i] = 1'b0;
          end else if (cyc == dm[i] + wlen[i]) begin
            fin[i]       = cyc + 1;
            fin_abort[i] = 1'b1;
          end
        end
        if (clr_v[i]) begin
          over[i] = 1'b0;
          tmo[i]  = 1'b0;
        end
        if (tick_now && busy_now) over[i] = 1'b1;
        if (end_now) begin
          if (fin_abort[i]) begin
            tmo[i] = 1'b1;
          end else if (pending[i] || swap_v[i]) begin
            bank[i]    = ~bank[i];
            pending[i] = 1'b0;
            ack_at[i]  = cyc + 1;
            swapped    = 1'b1;
          end
          dm[i]  = -1;
          fin[i] = -1;
        end
        if (swap_v[i] && !swapped) pending[i] = 1'b1;
        if (tick_now && en_v[i] && idle_now) dm[i] = cyc + 1;
      end
    end
    if (reset) cyc = 0;
    else cyc++;
  endtask

  task automatic applyStimulus();
    int d;
    reset       = force_reset;
    force_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (dm[i] == cyc) begin
        d = halt_delay[i];
        if (d < 0) d = delay_tab[$urandom_range(0, 9)];
        halt_at[i] = (d == 0) ? -1 : cyc + d;
      end
      halt_v[i] = (halt_at[i] == cyc) || (random_mode && ($urandom_range(0, 99) == 0));
      swap_v[i] = ((swap_mode == 1) && (dm[i] >= 0) && (cyc == dm[i] + 5)) ||
                  ((swap_mode == 2) && ($urandom_range(0, 39) == 0));
      clr_v[i]  = clr_pulse || (random_mode && ($urandom_range(0, 59) == 0));
      en_v[i]   = en_level;
    end
    clr_pulse = 1'b0;
    if (random_mode && ($urandom_range(0, 149) == 0)) en_level = ~en_level;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput($sformatf("inst_a cyc %0d", cyc), obs_a, exp_outputs(0));
      checkOutput($sformatf("inst_b cyc %0d", cyc), obs_b, exp_outputs(1));
      model_update();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit found;
    wlen[0] = WA;
    wlen[1] = WB;
    model_clear(0);
    model_clear(1);
    halt_delay[0] = 10;
    halt_delay[1] = 10;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Plain frames: halt 10 cycles after each dmago
    en_level = 1'b1;
    run_cycles(350);

    // Host swap requested mid-DRAW of each frame
    swap_mode = 1;
    run_cycles(200);

    // No HALT at all: short watchdog aborts, long watchdog overruns; swaps stay pending
    halt_delay[0] = 0;
    halt_delay[1] = 0;
    run_cycles(320);

    // Long frames on the long-watchdog instance, then clear the stickies
    swap_mode     = 0;
    halt_delay[0] = 10;
    halt_delay[1] = 120;
    run_cycles(400);
    halt_delay[1] = 10;
    clr_pulse     = 1'b1;
    run_cycles(150);

    // HALT exactly on the last watchdog cycle of the short instance
    halt_delay[0] = 50;
    halt_delay[1] = 50;
    run_cycles(250);

    // Randomised traffic: halt delays, swaps, clears, enable toggles, stray halts
    halt_delay[0] = -1;
    halt_delay[1] = -1;
    swap_mode     = 2;
    random_mode   = 1'b1;
    run_cycles(2000);

    // Reset in the middle of a DRAW while the short instance draws bank 1
    random_mode   = 1'b0;
    en_level      = 1'b1;
    swap_mode     = 1;
    halt_delay[0] = 10;
    halt_delay[1] = 10;
    found         = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      if (bank[0] && (dm[0] >= 0) && (cyc > dm[0] + 1) && (fin[0] < 0)) found = 1'b1;
      else run_cycles(1);
    end
    checkOutput("reset_window_found", {8'd0, found}, 9'd1);
    checkOutput("pre_reset_bank_busy", {7'd0, bus_a.draw_bank, bus_a.busy}, 9'b000000011);
    force_reset = 1'b1;
    run_cycles(1);
    checkOutput("post_reset_idle",
                {4'd0, bus_a.draw_bank, bus_a.busy, bus_a.dmago, bus_a.dvg_abort, bus_a.host_swap_ack},
                9'd0);
    swap_mode = 0;
    run_cycles(250);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
